// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall encodings,
// word constants, controller state codes and the stall priority encoder.
package pipeline_ctrl_pkg;

    localparam int INST_ADDR_W = 32;

    localparam logic                   RST_ENABLE = 1'b1;
    localparam logic [INST_ADDR_W-1:0] ZERO_WORD  = '0;

    // Stall vector bits: [0]=pc [1]=if/id [2]=id/ex [3]=ex/mem [4]=mem/wb [5]=wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

    // The deepest requesting stage wins, because holding it also has to hold
    // everything upstream of it.
    function automatic logic [5:0] stall_encode(input logic req_id,
                                                input logic req_ex,
                                                input logic req_mem);
        logic [5:0] enc;
        enc = STALL_NONE;
        if (req_mem) begin
            enc = STALL_MEM;
        end else if (req_ex) begin
            enc = STALL_EX;
        end else if (req_id) begin
            enc = STALL_ID;
        end
        return enc;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_monitor.sv
// Stall statistics: a saturating count of all stalled cycles, plus a
// consecutive-stall counter that raises a sticky timeout on runaway stalls.
module pipeline_ctrl_stall_monitor
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_active,
    input  logic             clr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    localparam int                CONS_W   = $clog2(TIMEOUT_CYC);
    localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0]  cyc_q,  cyc_d;
    logic [CONS_W-1:0] cons_q, cons_d;
    logic              tmo_q,  tmo_d;

    // Next-state for the total counter (saturating) and the run-length tracker.
    always_comb begin
        cyc_d  = cyc_q;
        cons_d = cons_q;
        tmo_d  = tmo_q;
        if (stall_active && (cyc_q != {CNT_W{1'b1}})) begin
            cyc_d = cyc_q + 1'b1;
        end
        if (clr || !stall_active) begin
            cons_d = '0;
        end else if (cons_q == CONS_MAX) begin
            // Run length has reached the limit and the stall is still present.
            tmo_d = 1'b1;
        end else begin
            cons_d = cons_q + 1'b1;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cyc_q  <= '0;
            cons_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            cons_q <= cons_d;
            tmo_q  <= tmo_d;
        end
    end

    assign stall_cycles  = cyc_q;
    assign stall_timeout = tmo_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Encodes stage stall
// requests into a per-register hold vector and sequences exception flushes.
//
//   state      | meaning
//   CTRL_RUN   | normal operation, stall requests honoured, exceptions accepted
//   CTRL_FLUSH | flush held for FLUSH_CYCLES cycles, all requests ignored
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   excp_req,
    input  logic [INST_ADDR_W-1:0] excp_vector,
    output logic [5:0]             stall,
    output logic                   flush,
    output logic [INST_ADDR_W-1:0] new_pc,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic                   stall_timeout
);

    ctrl_state_e            state_q,  state_d;
    logic                   flush_q,  flush_d;
    logic [INST_ADDR_W-1:0] new_pc_q, new_pc_d;
    logic [3:0]             fcnt_q,   fcnt_d;

    // Stall is only honoured in RUN with no exception pending, and never in reset.
    always_comb begin
        stall = STALL_NONE;
        if ((rst != RST_ENABLE) && (state_q == CTRL_RUN) && !excp_req) begin
            stall = stall_encode(stallreq_id, stallreq_ex, stallreq_mem);
        end
    end

    // Controller next-state: accept an exception in RUN, count down the flush.
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        new_pc_d = new_pc_q;
        fcnt_d   = fcnt_q;
        case (state_q)
            CTRL_RUN: begin
                if (excp_req) begin
                    state_d  = CTRL_FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = excp_vector;
                    fcnt_d   = 4'(FLUSH_CYCLES - 1);
                end
            end
            CTRL_FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = CTRL_RUN;
                    flush_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = CTRL_RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs; reset drops any flush in progress.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q  <= CTRL_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= ZERO_WORD;
            fcnt_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign flush  = flush_q;
    assign new_pc = new_pc_q;

    pipeline_ctrl_stall_monitor #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stall_monitor (
        .clk           (clk),
        .rst           (rst),
        .stall_active  (|stall),
        .clr           (state_q == CTRL_FLUSH),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

endmodule
